screen_draw_arbiter: RTL

//  Owns the VGA plot port. Shares it between two requesters: the full-screen picture blitter
//  (title/win/lose ROMs) and the game-object drawer (ball, paddle, bricks).

---
 rtl/screen_draw_arbiter_pkg.sv | 28 ++
 rtl/screen_draw_arbiter_if.sv | 42 ++++
 rtl/screen_draw_arbiter_pic_scan_counter.sv | 49 ++++
 rtl/screen_draw_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/screen_draw_arbiter_pkg.sv
// Shared definitions for the screen draw arbiter: screen ids, default
// geometry, FSM state encoding and the picture-select normaliser.
package screen_draw_arbiter_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  localparam logic [1:0] SCR_TITLE = 2'd0;
  localparam logic [1:0] SCR_WIN   = 2'd1;
  localparam logic [1:0] SCR_LOSE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PIC_RUN   = 2'd1,
    ST_PIC_FLUSH = 2'd2,
    ST_OBJ_GRANT = 2'd3
  } arb_state_e;

  // Unknown screen id 3 falls back to the title picture.
  function automatic logic [1:0] norm_select(input logic [1:0] sel);
    case (sel)
      SCR_WIN:  return SCR_WIN;
      SCR_LOSE: return SCR_LOSE;
      default:  return SCR_TITLE;
    endcase
  endfunction

endpackage

// File: rtl/screen_draw_arbiter_if.sv
// Bus between the arbiter and its neighbours: game FSM picture control,
// picture ROM, object drawer and the VGA plot port.
interface screen_draw_arbiter_if #(
  parameter int ADDR_W   = 15,
  parameter int COORD_W  = 10,
  parameter int COLOUR_W = 2
);
  logic                pic_start;
  logic [1:0]          pic_select;
  logic                pic_busy;
  logic                pic_done;
  logic [ADDR_W-1:0]   rom_address;
  logic [1:0]          rom_select;
  logic [COLOUR_W-1:0] rom_colour;
  logic                obj_req;
  logic                obj_gnt;
  logic                obj_release;
  logic [COORD_W-1:0]  obj_x;
  logic [COORD_W-1:0]  obj_y;
  logic [COLOUR_W-1:0] obj_colour;
  logic                obj_plot;
  logic [COORD_W-1:0]  vga_x;
  logic [COORD_W-1:0]  vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  // Arbiter side.
  modport slave (
    input  pic_start, pic_select, rom_colour,
    input  obj_req, obj_release, obj_x, obj_y, obj_colour, obj_plot,
    output pic_busy, pic_done, rom_address, rom_select, obj_gnt,
    output vga_x, vga_y, vga_colour, vga_plot
  );

  // Environment side (game FSM, ROM, object drawer, VGA adapter).
  modport master (
    output pic_start, pic_select, rom_colour,
    output obj_req, obj_release, obj_x, obj_y, obj_colour, obj_plot,
    input  pic_busy, pic_done, rom_address, rom_select, obj_gnt,
    input  vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/screen_draw_arbiter_pic_scan_counter.sv
// Raster scan counter for picture blits: linear ROM address plus x/y kept
// in step without a divide. Stops at the last pixel instead of wrapping.
module screen_draw_arbiter_pic_scan_counter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int ADDR_W   = 15,
  parameter int COORD_W  = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear_i,
  input  logic               step_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_o
);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(SCREEN_W - 1);

  logic [ADDR_W-1:0]  addr_q;
  logic [COORD_W-1:0] x_q, y_q;

  assign last_o = (addr_q == LAST_ADDR);
  assign addr_o = addr_q;
  assign x_o    = x_q;
  assign y_o    = y_q;

  // Advance one pixel per step; x wraps at the row end and bumps y.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (clear_i) begin
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (step_i && !last_o) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (x_q == X_MAX) begin
        x_q <= '0;
        y_q <= y_q + COORD_W'(1);
      end else begin
        x_q <= x_q + COORD_W'(1);
      end
    end
  end
endmodule

// File: rtl/screen_draw_arbiter.sv
// Owns the VGA plot port and shares it between the full-screen picture
// blitter and the game-object drawer. Picture scans are sequenced here and
// the plot is delayed to line up with the ROM read latency.
module screen_draw_arbiter
  import screen_draw_arbiter_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int ADDR_W      = 15,
  parameter int COORD_W     = 10,
  parameter int COLOUR_W    = 2,
  parameter int ROM_LATENCY = 1
) (
  input logic                 clk,
  input logic                 resetn,
  screen_draw_arbiter_if.slave bus
);
  localparam int TAP = ROM_LATENCY - 1;

  arb_state_e         state_q;
  logic               pend_q;
  logic [1:0]         pend_sel_q, sel_q;
  logic               gnt_q, done_q;

  logic [ADDR_W-1:0]  cnt_addr;
  logic [COORD_W-1:0] cnt_x, cnt_y;
  logic               cnt_last;
  logic               start_now, issue_vld;

  logic [ROM_LATENCY-1:0]              vld_pipe_q, last_pipe_q;
  logic [ROM_LATENCY-1:0][COORD_W-1:0] x_pipe_q, y_pipe_q;

  logic [COORD_W-1:0]  vga_x_q, vga_y_q;
  logic [COLOUR_W-1:0] vga_colour_q;
  logic                vga_plot_q;

  assign start_now = (state_q == ST_IDLE) && (bus.pic_start || pend_q);
  assign issue_vld = (state_q == ST_PIC_RUN);

  screen_draw_arbiter_pic_scan_counter #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .ADDR_W(ADDR_W), .COORD_W(COORD_W)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear_i(start_now),
    .step_i (issue_vld),
    .addr_o (cnt_addr),
    .x_o    (cnt_x),
    .y_o    (cnt_y),
    .last_o (cnt_last)
  );

  // Arbiter FSM: picture starts (fresh or pending) beat object requests;
  // an object burst runs to completion and defers any picture start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      pend_sel_q <= SCR_TITLE;
      sel_q      <= SCR_TITLE;
      gnt_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.pic_start || pend_q) begin
            state_q <= ST_PIC_RUN;
            sel_q   <= bus.pic_start ? norm_select(bus.pic_select) : pend_sel_q;
            pend_q  <= 1'b0;
          end else if (bus.obj_req) begin
            state_q <= ST_OBJ_GRANT;
          end
        end
        ST_PIC_RUN:   if (cnt_last) state_q <= ST_PIC_FLUSH;
        ST_PIC_FLUSH: if (last_pipe_q[TAP]) state_q <= ST_IDLE;
        ST_OBJ_GRANT: begin
          if (bus.obj_release || !bus.obj_req) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
          end else begin
            gnt_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // One-deep pending slot; a later start only refreshes the select.
      if (bus.pic_start && state_q != ST_IDLE) begin
        pend_q     <= 1'b1;
        pend_sel_q <= norm_select(bus.pic_select);
      end
    end
  end

  // Carry pixel coordinate and valid/last alongside the ROM read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      x_pipe_q    <= '0;
      y_pipe_q    <= '0;
    end else begin
      vld_pipe_q[0]  <= issue_vld;
      last_pipe_q[0] <= issue_vld && cnt_last;
      x_pipe_q[0]    <= cnt_x;
      y_pipe_q[0]    <= cnt_y;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
        x_pipe_q[i]    <= x_pipe_q[i-1];
        y_pipe_q[i]    <= y_pipe_q[i-1];
      end
    end
  end

  // Plot port register: picture pixel when its ROM data lands, otherwise
  // the granted object drawer, otherwise no write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= last_pipe_q[TAP];
      if (vld_pipe_q[TAP]) begin
        vga_x_q      <= x_pipe_q[TAP];
        vga_y_q      <= y_pipe_q[TAP];
        vga_colour_q <= bus.rom_colour;
        vga_plot_q   <= 1'b1;
      end else if (gnt_q) begin
        vga_x_q      <= bus.obj_x;
        vga_y_q      <= bus.obj_y;
        vga_colour_q <= bus.obj_colour;
        vga_plot_q   <= bus.obj_plot;
      end else begin
        vga_plot_q   <= 1'b0;
      end
    end
  end

  assign bus.pic_busy    = pend_q || (state_q == ST_PIC_RUN) || (state_q == ST_PIC_FLUSH);
  assign bus.pic_done    = done_q;
  assign bus.rom_address = cnt_addr;
  assign bus.rom_select  = sel_q;
  assign bus.obj_gnt     = gnt_q;
  assign bus.vga_x       = vga_x_q;
  assign bus.vga_y       = vga_y_q;
  assign bus.vga_colour  = vga_colour_q;
  assign bus.vga_plot    = vga_plot_q;
endmodule
